axis_conv_out_serializer: RTL

- AXIS receiver for the conv engine output stream.
- Accepts one wide accumulator beat, holding all MEMBERS words per copy/group/unit.
- Emits that beat as MEMBERS narrow beats, one member per beat, toward the downstream depthwise/pooling path.
- Zero-bubble: holds one wide beat, and a new wide beat is accepted in the same cycle the last member beat leaves.

---
 rtl/axis_conv_out_serializer.sv | 97 +++++++++
 1 files changed

// File: rtl/axis_conv_out_serializer.sv
// rtl/axis_conv_out_serializer.sv - splits one wide conv accumulator beat into MEMBERS narrow beats.
// Optional member index output enabled by AXIS_CONV_OUT_MEMBER_IDX_EN.
module axis_conv_out_serializer #(
    parameter  int COPIES      = 2,
    parameter  int GROUPS      = 2,
    parameter  int MEMBERS     = 8,
    parameter  int UNITS       = 4,
    parameter  int WORD_WIDTH  = 32,
    parameter  int TUSER_WIDTH = 8,
    localparam int CNT_W       = (MEMBERS > 1) ? $clog2(MEMBERS) : 1,
    localparam int IN_W        = COPIES * GROUPS * MEMBERS * UNITS * WORD_WIDTH,
    localparam int OUT_W       = COPIES * GROUPS * UNITS * WORD_WIDTH
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [IN_W-1:0]        s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
`ifdef AXIS_CONV_OUT_MEMBER_IDX_EN
    output logic [CNT_W-1:0]       m_axis_tmember,
`endif
    output logic [OUT_W-1:0]       m_axis_tdata
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IN_W-1:0]        r_data;
    logic [TUSER_WIDTH-1:0] r_user;
    logic                   r_last;

    logic w_last_member;
    logic w_out_fire;
    logic w_in_fire;

    assign w_last_member = (r_cnt == CNT_W'(MEMBERS - 1));
    assign w_out_fire    = (r_state == S_FULL) && m_axis_tready;

    // Ready opens on the final member handshake so wide beats stream without a bubble.
    assign s_axis_tready = !rst && ((r_state == S_EMPTY) || (w_out_fire && w_last_member));
    assign w_in_fire     = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
            r_data  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
        end else if (w_in_fire) begin
            r_state <= S_FULL;
            r_cnt   <= '0;
            r_data  <= s_axis_tdata;
            r_user  <= s_axis_tuser;
            r_last  <= s_axis_tlast;
        end else if (w_out_fire) begin
            if (w_last_member) begin
                r_state <= S_EMPTY;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign m_axis_tvalid = (r_state == S_FULL);
    assign m_axis_tlast  = r_last && w_last_member;
    assign m_axis_tuser  = r_user;

`ifdef AXIS_CONV_OUT_MEMBER_IDX_EN
    assign m_axis_tmember = m_axis_tvalid ? r_cnt : '0;
`endif

    // Held layout is [copy][group][member][unit][word]; pick the current member for each copy/group.
    always_comb begin
        m_axis_tdata = '0;
        for (int c = 0; c < COPIES; c++) begin
            for (int g = 0; g < GROUPS; g++) begin
                for (int u = 0; u < UNITS; u++) begin
                    m_axis_tdata[((c * GROUPS + g) * UNITS + u) * WORD_WIDTH +: WORD_WIDTH] =
                        r_data[(((c * GROUPS + g) * MEMBERS + int'(r_cnt)) * UNITS + u) * WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

endmodule
